// File: rtl/instr_fetch_mem.sv
// Instruction memory for fetch: program-load port, valid/ready fetch with
// 1-cycle registered response and fault code, post-reset clear engine.
// Ports: clk, reset; load_en/addr/data -> load_ready, load_err;
//   req_valid/addr -> req_ready; rsp_valid/instr/fault <- rsp_ready;
//   clear_busy.
module instr_fetch_mem #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 128,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_err,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [1:0]            rsp_fault,
  output logic                  clear_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         clear_ptr;

  logic [PW-1:0] req_idx;
  logic [PW-1:0] load_idx;
  logic [1:0]    req_fault;
  logic [1:0]    load_fault;
  logic          accept;
  logic          load_ok;
  logic          load_bad;

  // Range check uses the full address so high bits never alias.
  // Misalignment takes priority over out-of-range.
  function automatic logic [1:0] fault_of(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [1:0] f;
    f = 2'b00;
    priority case (1'b1)
      (a[1:0] != 2'b00):     f = 2'b01;
      ((a >> 2) > LAST_IDX): f = 2'b10;
      default:               f = 2'b00;
    endcase
    return f;
  endfunction

  assign req_idx    = req_addr[PW+1:2];
  assign load_idx   = load_addr[PW+1:2];
  assign req_fault  = fault_of(req_addr);
  assign load_fault = fault_of(load_addr);

  always_comb begin
    state_nxt  = state;
    clear_busy = 1'b0;
    load_ready = 1'b0;
    req_ready  = 1'b0;
    unique case (state)
      S_CLEAR: begin
        clear_busy = 1'b1;
        if (clear_ptr == LAST_PTR) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        load_ready = 1'b1;
        req_ready  = !rsp_valid || rsp_ready;
      end
    endcase
  end

  assign accept   = req_valid && req_ready;
  assign load_ok  = load_ready && load_en &&
                    (load_fault == 2'b00);
  assign load_bad = load_ready && load_en &&
                    (load_fault != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clear_ptr <= '0;
    end else if (clear_busy) begin
      clear_ptr <= (clear_ptr == LAST_PTR) ?
                   '0 : clear_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_busy) begin
        mem[clear_ptr] <= '0;
      end else if (load_ok) begin
        mem[load_idx] <= load_data;
      end
    end
  end

  // Read samples the array before this edge's write lands,
  // giving read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_instr <= '0;
      rsp_fault <= 2'b00;
      load_err  <= 1'b0;
    end else begin
      load_err <= load_bad;
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_fault <= req_fault;
        rsp_instr <= (req_fault == 2'b00) ?
                     mem[req_idx] : '0;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: directed loads/fetches,
// faults, backpressure, collisions, reset and clear behaviour.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic        load_err;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        clear_busy;

  logic        reset0 = 1'b1;
  logic        load_en0 = 1'b0;
  logic [31:0] load_addr0 = '0;
  logic [31:0] load_data0 = '0;
  logic        load_ready0;
  logic        load_err0;
  logic        req_valid0 = 1'b0;
  logic [31:0] req_addr0 = '0;
  logic        req_ready0;
  logic        rsp_valid0;
  logic [31:0] rsp_instr0;
  logic [1:0]  rsp_fault0;
  logic        clear_busy0;

  instr_fetch_mem dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .load_ready(load_ready),
    .load_err(load_err),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .clear_busy(clear_busy)
  );

  instr_fetch_mem #(.CLEAR_ON_RESET(1'b0)) dut0 (
    .clk(clk), .reset(reset0),
    .load_en(load_en0), .load_addr(load_addr0),
    .load_data(load_data0), .load_ready(load_ready0),
    .load_err(load_err0),
    .req_valid(req_valid0), .req_addr(req_addr0),
    .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_ready(1'b1),
    .rsp_instr(rsp_instr0), .rsp_fault(rsp_fault0),
    .clear_busy(clear_busy0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  fault;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   fresh = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (fresh) begin
        first_cyc = cyc;
        fresh = 1'b0;
      end
      if (rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
          chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
          chk("rsp_latency", 64'(first_cyc), 64'(e.cyc));
        end
        fresh = 1'b1;
      end
    end else begin
      fresh = 1'b1;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Counts busy cycles; stop_at > 0 aborts after that many.
  task automatic count_clear(input int stop_at,
                             input bit drive_load,
                             output int n);
    int rdy_bad;
    int err_seen;
    n = 0;
    rdy_bad = 0;
    err_seen = 0;
    if (drive_load) begin
      load_en = 1'b1;
      load_addr = 32'h100;
      load_data = 32'hFFFF_FFFF;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) chk("rsp_valid_after_reset",
                      64'(rsp_valid), 64'd0);
      if (clear_busy !== 1'b1) begin
        load_en = 1'b0;
        break;
      end
      n++;
      if (req_ready !== 1'b0) rdy_bad++;
      if (load_err !== 1'b0) err_seen++;
      if (stop_at > 0 && n == stop_at) break;
    end
    load_en = 1'b0;
    chk("req_ready_during_clear", 64'(rdy_bad), 64'd0);
    chk("load_err_during_clear", 64'(err_seen), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic exp_err);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(negedge clk);
    chk("load_err", 64'(load_err), 64'(exp_err));
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_err_one_cycle", 64'(load_err), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] ei,
                       input logic [1:0] ef);
    exp_t e;
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        e.instr = ei;
        e.fault = ef;
        e.cyc = cyc + 1;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL fetch_timeout addr=%h", a);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    @(posedge clk);
    do_reset();
    count_clear(0, 1'b0, n);
    chk("clear_len_initial", 64'(n), 64'd128);
    @(negedge clk);
    chk("load_ready_run", 64'(load_ready), 64'd1);
    chk("clear_busy_run", 64'(clear_busy), 64'd0);
    @(posedge clk); #1;
    fetch(32'h1FC, 32'h0, 2'b00);
    idle(2);

    load(32'h0, 32'hDEAD_BEEF, 1'b0);
    load(32'h4, 32'h1234_5678, 1'b0);
    load(32'h1FC, 32'hCAFE_F00D, 1'b0);
    fetch(32'h0, 32'hDEAD_BEEF, 2'b00);
    fetch(32'h4, 32'h1234_5678, 2'b00);
    fetch(32'h1FC, 32'hCAFE_F00D, 2'b00);
    idle(2);

    fetch(32'h6, 32'h0, 2'b01);
    fetch(32'h200, 32'h0, 2'b10);
    fetch(32'h201, 32'h0, 2'b01);
    fetch(32'hFFFF_FFFC, 32'h0, 2'b10);
    idle(2);
    load(32'h200, 32'h1111_1111, 1'b1);
    load(32'h2, 32'h2222_2222, 1'b1);
    fetch(32'h0, 32'hDEAD_BEEF, 2'b00);
    fetch(32'h1FC, 32'hCAFE_F00D, 2'b00);
    idle(2);

    rsp_ready = 1'b0;
    fetch(32'h4, 32'h1234_5678, 2'b00);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_instr", 64'(rsp_instr), 64'h1234_5678);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    idle(2);

    load_en = 1'b1;
    load_addr = 32'h8;
    load_data = 32'hAAAA_5555;
    fetch(32'h8, 32'h0, 2'b00);
    load_en = 1'b0;
    fetch(32'h8, 32'hAAAA_5555, 2'b00);
    idle(3);

    do_reset();
    count_clear(40, 1'b0, n);
    chk("clear_partial", 64'(n), 64'd40);
    do_reset();
    count_clear(0, 1'b1, n);
    chk("clear_len_restart", 64'(n), 64'd128);
    fetch(32'h1FC, 32'h0, 2'b00);
    fetch(32'h100, 32'h0, 2'b00);
    fetch(32'h0, 32'h0, 2'b00);
    idle(2);

    load(32'h0, 32'h0BAD_F00D, 1'b0);
    rsp_ready = 1'b0;
    fetch(32'h0, 32'h0BAD_F00D, 2'b00);
    req_valid = 1'b0;
    @(negedge clk);
    chk("valid_before_reset", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    do_reset();
    sb.delete();
    rsp_ready = 1'b1;
    count_clear(0, 1'b0, n);
    chk("clear_len_rsp_reset", 64'(n), 64'd128);

    @(posedge clk); #1;
    reset0 = 1'b0;
    @(negedge clk);
    chk("nc_req_ready", 64'(req_ready0), 64'd1);
    chk("nc_clear_busy", 64'(clear_busy0), 64'd0);
    @(posedge clk); #1;
    load_en0 = 1'b1;
    load_addr0 = 32'h10;
    load_data0 = 32'h5A5A_1234;
    @(posedge clk); #1;
    load_en0 = 1'b0;
    reset0 = 1'b1;
    @(posedge clk); #1;
    reset0 = 1'b0;
    @(negedge clk);
    chk("nc_req_ready_after", 64'(req_ready0), 64'd1);
    chk("nc_rsp_valid_after", 64'(rsp_valid0), 64'd0);
    @(posedge clk); #1;
    req_valid0 = 1'b1;
    req_addr0 = 32'h10;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    @(negedge clk);
    chk("nc_rsp_valid", 64'(rsp_valid0), 64'd1);
    chk("nc_rsp_instr", 64'(rsp_instr0), 64'h5A5A_1234);
    chk("nc_rsp_fault", 64'(rsp_fault0), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
